tron_player_ctrl: RTL

//  Per-player motion stage that feeds tron_mem_controller. On each game tick it applies

---
 rtl/tron_player_ctrl_if.sv | 31 +++
 rtl/tron_player_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tron_player_ctrl_if.sv
// ---------------------------------------------------------------------------
// tron_player_ctrl_if
// Trail write/check channel between a player motion stage and the
// tron_mem_controller.
//   addr_x             8  head x cell of the current request
//   addr_y             7  head y cell of the current request
//   wr_en              1  one-cycle trail write/check request
//   collision_detected 1  result of the check, returned by the memory side
// master : player controller side (drives the request, reads the result)
// slave  : memory controller side
// ---------------------------------------------------------------------------
interface tron_player_ctrl_if;
    logic [7:0] addr_x;
    logic [6:0] addr_y;
    logic       wr_en;
    logic       collision_detected;

    modport master (
        output addr_x,
        output addr_y,
        output wr_en,
        input  collision_detected
    );

    modport slave (
        input  addr_x,
        input  addr_y,
        input  wr_en,
        output collision_detected
    );
endinterface

// File: rtl/tron_player_ctrl.sv
// ---------------------------------------------------------------------------
// tron_player_ctrl
// Per-player motion stage. On each game tick in RUN it applies the latched
// turn requests, advances the head one cell with wrap-around and issues a
// one-cycle trail write/check request. CHECK_LAT cycles after the request it
// samples collision_detected and either returns to RUN or kills the player.
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   game_tick     one-cycle move strobe
//   start         level, begins/restarts a round from IDLE or DEAD
//   btn_left      raw level, turn counter-clockwise on rising edge
//   btn_right     raw level, turn clockwise on rising edge
//   mem           request channel to the memory controller (master side)
//   dir           current direction (0 up, 1 right, 2 down, 3 left)
//   alive         high in RUN/ISSUE/WAIT
//   died          one-cycle pulse on entry to DEAD
//   step_count    cells moved this round, saturating
//   tick_overrun  sticky, a tick arrived in ISSUE or WAIT
// ---------------------------------------------------------------------------
module tron_player_ctrl #(
    parameter int GRID_W    = 160,
    parameter int GRID_H    = 120,
    parameter int START_X   = 40,
    parameter int START_Y   = 60,
    parameter int START_DIR = 1,
    parameter int CHECK_LAT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       game_tick,
    input  logic                       start,
    input  logic                       btn_left,
    input  logic                       btn_right,
    tron_player_ctrl_if.master         mem,
    output logic [1:0]                 dir,
    output logic                       alive,
    output logic                       died,
    output logic [15:0]                step_count,
    output logic                       tick_overrun
);

    // The wait counter only needs to hold CHECK_LAT-1.
    localparam int CW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RUN,
        S_DEAD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic [7:0]      x_q;
    logic [6:0]      y_q;
    logic [1:0]      dir_q;
    logic [15:0]     steps_q;
    logic            overrun_q;
    logic            died_q;
    logic            left_pend;
    logic            right_pend;
    logic            left_prev;
    logic            right_prev;

    logic            left_rise;
    logic            right_rise;
    logic            check_done;
    logic [1:0]      dir_turned;
    logic [7:0]      x_step;
    logic [6:0]      y_step;

    assign left_rise  = btn_left  & ~left_prev;
    assign right_rise = btn_right & ~right_prev;
    assign check_done = (state == S_WAIT) && (wait_cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Restarts are only honoured from IDLE or DEAD, and
    // the collision result is consumed on the last WAIT cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DEAD: if (start)     state_next = S_ISSUE;
            S_ISSUE:                       state_next = S_WAIT;
            S_WAIT:         if (check_done) state_next = mem.collision_detected ? S_DEAD : S_RUN;
            S_RUN:          if (game_tick) state_next = S_ISSUE;
            default:                       state_next = S_IDLE;
        endcase
    end

    // Output decode. The request is exactly the ISSUE cycle, so it can
    // never be high on two consecutive cycles.
    always_comb begin
        mem.wr_en    = (state == S_ISSUE);
        alive        = (state == S_ISSUE) || (state == S_WAIT) || (state == S_RUN);
        mem.addr_x   = x_q;
        mem.addr_y   = y_q;
        dir          = dir_q;
        died         = died_q;
        step_count   = steps_q;
        tick_overrun = overrun_q;
    end

    // Turn resolution and wrap-around step. Bounds are compared before the
    // add/subtract so no intermediate wider than the port is needed.
    always_comb begin
        dir_turned = dir_q;
        if (left_pend && !right_pend) begin
            dir_turned = dir_q - 2'd1;
        end else if (right_pend && !left_pend) begin
            dir_turned = dir_q + 2'd1;
        end

        x_step = x_q;
        y_step = y_q;
        unique case (dir_turned)
            2'd0: y_step = (y_q == 7'd0) ? 7'(GRID_H - 1) : y_q - 7'd1;
            2'd1: x_step = (x_q == 8'(GRID_W - 1)) ? 8'd0 : x_q + 8'd1;
            2'd2: y_step = (y_q == 7'(GRID_H - 1)) ? 7'd0 : y_q + 7'd1;
            2'd3: x_step = (x_q == 8'd0) ? 8'(GRID_W - 1) : x_q - 8'd1;
        endcase
    end

    // Datapath registers. Turn edges are latched in every alive state; a
    // tick consumes the latches that existed before it, while an edge seen
    // on the tick cycle itself is kept for the following tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt   <= '0;
            x_q        <= 8'(START_X);
            y_q        <= 7'(START_Y);
            dir_q      <= 2'(START_DIR);
            steps_q    <= 16'd0;
            overrun_q  <= 1'b0;
            died_q     <= 1'b0;
            left_pend  <= 1'b0;
            right_pend <= 1'b0;
            left_prev  <= 1'b0;
            right_prev <= 1'b0;
        end else begin
            left_prev  <= btn_left;
            right_prev <= btn_right;
            died_q     <= check_done && mem.collision_detected;

            unique case (state)
                S_IDLE, S_DEAD: begin
                    if (start) begin
                        x_q        <= 8'(START_X);
                        y_q        <= 7'(START_Y);
                        dir_q      <= 2'(START_DIR);
                        steps_q    <= 16'd0;
                        overrun_q  <= 1'b0;
                        left_pend  <= 1'b0;
                        right_pend <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    wait_cnt   <= CW'(CHECK_LAT - 1);
                    if (game_tick) overrun_q <= 1'b1;
                    left_pend  <= left_pend  | left_rise;
                    right_pend <= right_pend | right_rise;
                end
                S_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    if (game_tick) overrun_q <= 1'b1;
                    left_pend  <= left_pend  | left_rise;
                    right_pend <= right_pend | right_rise;
                end
                S_RUN: begin
                    if (game_tick) begin
                        dir_q      <= dir_turned;
                        x_q        <= x_step;
                        y_q        <= y_step;
                        if (steps_q != 16'hFFFF) steps_q <= steps_q + 16'd1;
                        left_pend  <= left_rise;
                        right_pend <= right_rise;
                    end else begin
                        left_pend  <= left_pend  | left_rise;
                        right_pend <= right_pend | right_rise;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
